cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 124 ++++++++++++
 tb/tb_cpu_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for a small accumulator CPU: steps FETCH/DECODE/EXECUTE,
// owns the program counter, instruction register and retired-instruction counter.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic [11:0] rom_data,
  input  logic        cu_we,
  input  logic        cu_we_acc,
  input  logic        cu_sel_pc,
  input  logic        cu_sel_br,
  output logic [7:0]  rom_addr,
  output logic [3:0]  ir_opcode,
  output logic [7:0]  ir_k,
  output logic        ram_we,
  output logic        acc_we,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  // state   | meaning
  // IDLE    | waiting for run (free-running) or step (single instruction)
  // FETCH   | latch ROM word into IR
  // DECODE  | control unit settles on the new IR
  // EXECUTE | gated write enables, PC update, retire count
  // HALT    | self-loop detected; only reset leaves
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_EXECUTE = 3'b011,
    S_HALT    = 3'b100
  } state_t;

  localparam logic [3:0] OP_HALT_JMP = 4'b0110;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  k_q, k_d;
  logic [15:0] cnt_q, cnt_d;
  logic        single_q, single_d;
  logic        in_exec;
  logic        halt_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= 8'h00;
      op_q     <= 4'h0;
      k_q      <= 8'h00;
      cnt_q    <= 16'h0000;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
    end
  end

  assign in_exec  = (state_q == S_EXECUTE);
  // A jump-to-self opcode at its own address can never make progress.
  assign halt_hit = (op_q == OP_HALT_JMP) && (k_q == pc_q);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    op_d     = op_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    single_d = single_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_FETCH;
          single_d = 1'b0;
        end else if (step) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
        end
      end
      S_FETCH: begin
        op_d    = rom_data[11:8];
        k_d     = rom_data[7:0];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (halt_hit) begin
          state_d = S_HALT;
        end else begin
          if (cu_sel_pc)      pc_d = k_q;
          else if (cu_sel_br) pc_d = pc_q + 8'd2;
          else                pc_d = pc_q + 8'd1;
          state_d = (run && !single_q) ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_we      = cu_we & in_exec;
  assign acc_we      = cu_we_acc & in_exec;
  assign halted      = (state_q == S_HALT);
  assign state       = state_q;
  assign rom_addr    = pc_q;
  assign ir_opcode   = op_q;
  assign ir_k        = k_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model predicts each
// EXECUTE; a negedge monitor pops and compares whenever the DUT is in EXECUTE.
module tb_cpu_sequencer;

  logic        clk, rst, run, step;
  logic [11:0] rom_data;
  logic        cu_we, cu_we_acc, cu_sel_pc, cu_sel_br;
  logic [7:0]  rom_addr;
  logic [3:0]  ir_opcode;
  logic [7:0]  ir_k;
  logic        ram_we, acc_we, halted;
  logic [2:0]  state;
  logic [15:0] instr_count;

  // program ROM and control-unit table {we, we_acc, sel_pc, sel_br} per opcode
  logic [11:0] rom [256];
  logic [3:0]  cu_tab [16];

  assign rom_data = rom[rom_addr];
  assign {cu_we, cu_we_acc, cu_sel_pc, cu_sel_br} = cu_tab[ir_opcode];

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .rom_data(rom_data),
    .cu_we(cu_we), .cu_we_acc(cu_we_acc), .cu_sel_pc(cu_sel_pc), .cu_sel_br(cu_sel_br),
    .rom_addr(rom_addr), .ir_opcode(ir_opcode), .ir_k(ir_k), .ram_we(ram_we),
    .acc_we(acc_we), .halted(halted), .state(state), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_HALT = 3'd4;

  typedef struct {
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [7:0]  k;
    logic        rw;
    logic        aw;
    logic [7:0]  pc_n;
    logic [15:0] cnt_n;
    logic [2:0]  st_n;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          post;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  bit          m_halt;

  logic [2:0] seq_st  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
  logic       seq_acc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: one call = one retired instruction.
  task automatic push_instr(input bit last);
    exp_t e;
    logic [11:0] w;
    logic [3:0]  c;
    w = rom[m_pc];
    c = cu_tab[w[11:8]];
    e.pc = m_pc; e.op = w[11:8]; e.k = w[7:0]; e.rw = c[3]; e.aw = c[2];
    e.cnt_n = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    if (w[11:8] == 4'h6 && w[7:0] == m_pc) begin
      e.pc_n = m_pc;
      e.st_n = ST_HALT;
      m_halt = 1'b1;
    end else begin
      if (c[1])      e.pc_n = w[7:0];
      else if (c[0]) e.pc_n = m_pc + 8'd2;
      else           e.pc_n = m_pc + 8'd1;
      e.st_n = last ? ST_IDLE : ST_FETCH;
    end
    m_pc  = e.pc_n;
    m_cnt = e.cnt_n;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      post = 1'b0;
    end else begin
      if (post) begin
        chk("pc_after", rom_addr, cur.pc_n);
        chk("count_after", instr_count, cur.cnt_n);
        chk("state_after", state, cur.st_n);
        post = 1'b0;
      end
      if (state == ST_EXEC) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_execute: got EXECUTE at pc 0x%0h, expected no instruction at %0t", rom_addr, $time);
        end else begin
          cur = q.pop_front();
          chk("exec_pc", rom_addr, cur.pc);
          chk("exec_opcode", ir_opcode, cur.op);
          chk("exec_k", ir_k, cur.k);
          chk("exec_ram_we", ram_we, cur.rw);
          chk("exec_acc_we", acc_we, cur.aw);
          post = 1'b1;
        end
      end else begin
        chk("we_outside_exec", {ram_we, acc_we}, 2'b00);
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, state, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk("queue_empty_before_reset", q.size(), 0);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    #1;
    chk("rst_state", state, ST_IDLE);
    chk("rst_pc", rom_addr, 8'h00);
    chk("rst_ir", {ir_opcode, ir_k}, 12'h000);
    chk("rst_count", instr_count, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_we", {ram_we, acc_we}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 8'h00; m_cnt = 16'h0000; m_halt = 1'b0;
    q.delete();
  endtask

  // Free-running burst of up to n instructions; run drops during the last FETCH.
  task automatic run_burst(input int n);
    int m = 0, execs = 0, cyc = 0;
    for (int i = 0; i < n && !m_halt; i++) begin
      push_instr(i == n - 1);
      m++;
    end
    run  = 1'b1;
    step = 1'($urandom_range(0, 1));
    while (cyc < 6 * m + 10) begin
      @(negedge clk);
      cyc++;
      if (state == ST_EXEC) execs++;
      if (run) step = 1'($urandom_range(0, 1));
      if (run && state == ST_FETCH && execs == m - 1) begin
        run = 1'b0; step = 1'b0;
      end
      if (execs == m && (state == ST_IDLE || state == ST_HALT)) break;
    end
    run = 1'b0; step = 1'b0;
    chk("burst_exec_count", execs, m);
    chk("burst_end_state", state, m_halt ? ST_HALT : ST_IDLE);
  endtask

  task automatic step_one(input bit pulse_in_decode);
    push_instr(1'b1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    if (pulse_in_decode) begin
      wait_state(ST_DECODE, 5, "step_reach_decode");
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
    wait_state(m_halt ? ST_HALT : ST_IDLE, 10, "step_end_state");
    repeat (3) begin
      @(negedge clk);
      chk("step_stays", state, m_halt ? ST_HALT : ST_IDLE);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; post = 1'b0;
    m_pc = 8'h00; m_cnt = 16'h0000; m_halt = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    for (int i = 0; i < 16; i++) cu_tab[i] = 4'h0;
    repeat (2) @(negedge clk);

    // two-instruction run with exact cycle-by-cycle state and acc_we
    do_reset();
    rom[0] = 12'hF05; rom[1] = 12'h103;
    cu_tab[4'hF] = 4'b0100; cu_tab[4'h1] = 4'b0100;
    push_instr(1'b0);
    push_instr(1'b1);
    run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      chk("seq_state", state, seq_st[c]);
      chk("seq_acc_we", acc_we, seq_acc[c]);
      if (c == 4) run = 1'b0;
      @(negedge clk);
    end
    chk("seq_final_state", state, ST_IDLE);
    chk("seq_final_pc", rom_addr, 8'h02);
    chk("seq_final_count", instr_count, 16'd2);

    // single step, with a stray step pulse during DECODE
    rom[2] = 12'h2AB; cu_tab[4'h2] = 4'b0000;
    step_one(1'b1);
    chk("step_pc", rom_addr, 8'h03);
    chk("step_count", instr_count, 16'd3);

    // RAM write gating, then reset during DECODE aborts the write
    rom[3] = 12'h520; cu_tab[4'h5] = 4'b1000;
    step_one(1'b0);
    do_reset();
    rom[0] = 12'h520;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_state(ST_DECODE, 5, "abort_reach_decode");
    rst = 1'b1;
    #1;
    chk("abort_state", state, ST_IDLE);
    chk("abort_ram_we", ram_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_stays_idle", state, ST_IDLE);
      chk("abort_count", instr_count, 16'd0);
    end

    // PC wrap cases and sel_pc priority over sel_br
    cu_tab[4'h1] = 4'b0010; cu_tab[4'h2] = 4'b0000; cu_tab[4'h3] = 4'b0001;
    cu_tab[4'h4] = 4'b0011;
    do_reset();
    rom[0] = 12'h1FF; rom[8'hFF] = 12'h200;
    run_burst(2);
    chk("wrap_ff_plus1", rom_addr, 8'h00);
    do_reset();
    rom[8'hFF] = 12'h300;
    run_burst(2);
    chk("wrap_ff_plus2", rom_addr, 8'h01);
    do_reset();
    rom[0] = 12'h1FE; rom[8'hFE] = 12'h300;
    run_burst(2);
    chk("wrap_fe_plus2", rom_addr, 8'h00);
    do_reset();
    rom[0] = 12'h440;
    run_burst(1);
    chk("sel_pc_priority", rom_addr, 8'h40);

    // counter saturation from a preloaded 0xFFFF
    do_reset();
    rom[0] = 12'h200;
    force dut.cnt_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.cnt_q;
    m_cnt = 16'hFFFF;
    run_burst(1);
    chk("count_saturates", instr_count, 16'hFFFF);

    // halt on jump-to-self, sticky against run/step
    do_reset();
    cu_tab[4'h6] = 4'b1100;
    rom[0] = 12'h110; rom[8'h10] = 12'h610;
    run_burst(5);
    chk("halt_flag", halted, 1'b1);
    chk("halt_pc", rom_addr, 8'h10);
    repeat (12) begin
      run  = 1'($urandom_range(0, 1));
      step = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_sticky_state", state, ST_HALT);
      chk("halt_sticky_flag", halted, 1'b1);
    end
    run = 1'b0; step = 1'b0;
    do_reset();

    // randomized programs and control-unit tables
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 256; i++) rom[i] = 12'($urandom);
      for (int i = 0; i < 16; i++) cu_tab[i] = 4'($urandom);
      if ($urandom_range(0, 2) == 0) step_one(1'($urandom_range(0, 1)));
      else run_burst(int'($urandom_range(1, 8)));
      if (m_halt) do_reset();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
